neuron_update_scheduler: RTL

- Time-multiplexes one shared potential_adder datapath across up to N_MAX neurons per timestep.
- On each timestep start, it walks neuron indices 0..num_neurons-1. For each index it:
  - reads potential and accumulated weight from neuron state memory,
  - presents them to the adder,
  - captures the result after ADDER_LAT cycles,
  - writes it back,
  - emits a spike event with a valid/ready handshake.
- Sits between the timestep controller, the neuron state memory and the spike network interface.

---
 rtl/neuron_update_scheduler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/neuron_update_scheduler.sv
// Sequences a shared potential adder over neurons 0..num_neurons-1 once per timestep.
// Optional spike counter output enabled by defining SPIKE_COUNT_EN.
module neuron_update_scheduler #(
    parameter int N_MAX     = 256,
    parameter int DW        = 32,
    parameter int ADDER_LAT = 1,
    localparam int NW       = (N_MAX > 1) ? $clog2(N_MAX) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ts_start,
    input  logic [NW:0]   num_neurons,
    output logic          busy,
    output logic          ts_done,
    output logic          mem_rd_en,
    output logic [NW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rd_potential,
    input  logic [DW-1:0] mem_rd_weight,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_wr_potential,
    output logic          add_clear,
    output logic [DW-1:0] add_decayed,
    output logic [DW-1:0] add_weight,
    input  logic [DW-1:0] add_final,
    input  logic          add_spike,
    output logic          spk_valid,
    input  logic          spk_ready,
`ifdef SPIKE_COUNT_EN
    output logic [NW:0]   spike_count,
`endif
    output logic [NW-1:0] spk_id
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_WAIT,
        S_WRITE,
        S_EMIT,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [NW:0] NMAX_W = (NW + 1)'(N_MAX);
    localparam logic [3:0]  LAT_W  = 4'(ADDER_LAT);

    state_t        state_q, state_d;
    logic [NW:0]   idx_q, idx_d;
    logic [NW:0]   count_q, count_d;
    logic [3:0]    wait_q, wait_d;
    logic [DW-1:0] dec_q, dec_d;
    logic [DW-1:0] wgt_q, wgt_d;
    logic [DW-1:0] final_q, final_d;
    logic          spike_q, spike_d;
    logic [NW:0]   idx_inc;
    logic [NW:0]   num_sat;
    logic          accept;

    assign idx_inc = idx_q + 1'b1;
    assign num_sat = (num_neurons > NMAX_W) ? NMAX_W : num_neurons;
    assign accept  = (state_q == S_IDLE) && ts_start;

    // The clear pulse coincides with the accepting cycle so it can never overlap ts_done.
    assign add_clear   = accept && rst_n;
    assign add_decayed = dec_q;
    assign add_weight  = wgt_q;

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        count_d          = count_q;
        wait_d           = wait_q;
        dec_d            = dec_q;
        wgt_d            = wgt_q;
        final_d          = final_q;
        spike_d          = spike_q;
        busy             = (state_q != S_IDLE);
        ts_done          = 1'b0;
        mem_rd_en        = 1'b0;
        mem_wr_en        = 1'b0;
        mem_addr         = '0;
        mem_wr_potential = '0;
        spk_valid        = 1'b0;
        spk_id           = '0;

        case (state_q)
            S_IDLE: begin
                if (ts_start) begin
                    count_d = num_sat;
                    idx_d   = '0;
                    state_d = (num_sat == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                mem_rd_en = 1'b1;
                mem_addr  = idx_q[NW-1:0];
                state_d   = S_LOAD;
            end
            S_LOAD: begin
                dec_d   = mem_rd_potential;
                wgt_d   = mem_rd_weight;
                wait_d  = LAT_W;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Last wait cycle: adder output has settled, capture it.
                if (wait_q <= 4'd1) begin
                    wait_d  = '0;
                    final_d = add_final;
                    spike_d = add_spike;
                    state_d = S_WRITE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_WRITE: begin
                mem_wr_en        = 1'b1;
                mem_addr         = idx_q[NW-1:0];
                mem_wr_potential = final_q;
                state_d          = spike_q ? S_EMIT : S_NEXT;
            end
            S_EMIT: begin
                spk_valid = 1'b1;
                spk_id    = idx_q[NW-1:0];
                if (spk_ready) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == count_q) ? S_DONE : S_READ;
            end
            S_DONE: begin
                ts_done = 1'b1;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            count_q <= '0;
            wait_q  <= '0;
            dec_q   <= '0;
            wgt_q   <= '0;
            final_q <= '0;
            spike_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            wait_q  <= wait_d;
            dec_q   <= dec_d;
            wgt_q   <= wgt_d;
            final_q <= final_d;
            spike_q <= spike_d;
        end
    end

`ifdef SPIKE_COUNT_EN
    logic [NW:0] spike_count_q, spike_count_d;

    always_comb begin
        spike_count_d = spike_count_q;
        if (accept) begin
            spike_count_d = '0;
        end else if (state_q == S_EMIT && spk_ready) begin
            spike_count_d = spike_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_count_q <= '0;
        end else begin
            spike_count_q <= spike_count_d;
        end
    end

    assign spike_count = spike_count_q;
`endif

endmodule
